// File: rtl/rot_pkg.sv
// rot_pkg: shared encodings for the rotation address generator.
//   - quarter-turn MODE encodings, DIR encodings, FSM states
//   - default address/dimension widths
//   - eff_turns(): folds MODE/DIR into clockwise quarter turns
package rot_pkg;

    localparam int ROT_AW = 32;
    localparam int ROT_DW = 16;

    typedef enum logic [1:0] {
        MODE_0   = 2'd0,
        MODE_90  = 2'd1,
        MODE_180 = 2'd2,
        MODE_270 = 2'd3
    } rot_mode_e;

    typedef enum logic {
        DIR_CW  = 1'b0,
        DIR_CCW = 1'b1
    } rot_dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } rot_state_e;

    // Counter-clockwise n turns == clockwise (4-n) turns; the 2-bit
    // truncation supplies the mod 4.
    function automatic logic [1:0] eff_turns(input logic [1:0] mode, input logic dir);
        return (dir == DIR_CCW) ? 2'(3'd4 - {1'b0, mode}) : mode;
    endfunction

endpackage

// File: rtl/rot_addr_gen_if.sv
// rot_addr_gen_if: address-pair handshake towards the DMA datapath.
//   valid   : address pair valid (master -> slave)
//   ready   : DMA accepts the pair (slave -> master)
//   rd_addr : source pixel address
//   wr_addr : destination pixel address
interface rot_addr_gen_if #(
    parameter int AW = rot_pkg::ROT_AW
);
    logic          valid;
    logic          ready;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;

    modport master (output valid, output rd_addr, output wr_addr, input ready);
    modport slave  (input valid, input rd_addr, input wr_addr, output ready);
endinterface

// File: rtl/rot_coord_map.sv
// rot_coord_map: combinational source->destination coordinate mapping.
//   r, c        : source row/col
//   h, w        : source height/width
//   q           : effective clockwise quarter turns
//   row, col    : destination row/col
//   new_h/new_w : rotated image dimensions
module rot_coord_map
    import rot_pkg::*;
#(
    parameter int DW = ROT_DW
) (
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] h,
    input  logic [DW-1:0] w,
    input  logic [1:0]    q,
    output logic [DW-1:0] row,
    output logic [DW-1:0] col,
    output logic [DW-1:0] new_h,
    output logic [DW-1:0] new_w
);

    always_comb begin
        row = r;
        col = c;
        case (q)
            MODE_90: begin
                row = c;
                col = h - DW'(1) - r;
            end
            MODE_180: begin
                row = h - DW'(1) - r;
                col = w - DW'(1) - c;
            end
            MODE_270: begin
                row = w - DW'(1) - c;
                col = r;
            end
            default: ;
        endcase
    end

    // Odd turn counts swap the image axes.
    assign new_h = q[0] ? w : h;
    assign new_w = q[0] ? h : w;

endmodule

// File: rtl/rot_addr_gen.sv
// rot_addr_gen: rotation core sequencer. Walks the source image in raster
// order and issues one read/write address pair per pixel over dma.
//   I_ROTAG_PCLK / I_ROTAG_PRESET_N : clock, synchronous active-low reset
//   I_ROTAG_SRC_IMG / DST_IMG       : base addresses
//   I_ROTAG_IMG_H / IMG_W           : source dimensions
//   I_ROTAG_MODE / DIR              : quarter turns, rotation direction
//   I_ROTAG_START                   : level; rising edge starts a job
//   I_ROTAG_SRESET                  : soft reset level
//   dma (master)                    : valid/ready, rd_addr, wr_addr
//   O_ROTAG_NEW_H / NEW_W           : rotated dimensions
//   O_ROTAG_BUSY / DONE             : job in progress / one-cycle end pulse
//   O_ROTAG_CYCLES                  : RUN cycle count
// Optional feature macro: ROTAG_PERF_CNT_EN enables the RUN cycle counter;
// without it O_ROTAG_CYCLES is tied to zero.
module rot_addr_gen
    import rot_pkg::*;
#(
    parameter int AW = ROT_AW,
    parameter int DW = ROT_DW
) (
    input  logic          I_ROTAG_PCLK,
    input  logic          I_ROTAG_PRESET_N,
    input  logic [AW-1:0] I_ROTAG_SRC_IMG,
    input  logic [AW-1:0] I_ROTAG_DST_IMG,
    input  logic [DW-1:0] I_ROTAG_IMG_H,
    input  logic [DW-1:0] I_ROTAG_IMG_W,
    input  logic [1:0]    I_ROTAG_MODE,
    input  logic          I_ROTAG_DIR,
    input  logic          I_ROTAG_START,
    input  logic          I_ROTAG_SRESET,
    rot_addr_gen_if.master dma,
    output logic [DW-1:0] O_ROTAG_NEW_H,
    output logic [DW-1:0] O_ROTAG_NEW_W,
    output logic          O_ROTAG_BUSY,
    output logic          O_ROTAG_DONE,
    output logic [31:0]   O_ROTAG_CYCLES
);

    rot_state_e    state;
    logic          start_q;
    logic [DW-1:0] r_q, c_q, h_q, w_q;
    logic [AW-1:0] src_q, dst_q;
    logic [1:0]    q_q;
    logic [DW-1:0] new_h_q, new_w_q;
    logic          valid_q, busy_q, done_q;

    // In LATCH the map sees the live config so the rotated dimensions can be
    // registered in the same cycle the config is captured.
    logic          in_latch;
    logic [DW-1:0] map_h, map_w, row, col, map_new_h, map_new_w;
    logic [1:0]    map_q;

    assign in_latch = (state == ST_LATCH);
    assign map_h    = in_latch ? I_ROTAG_IMG_H : h_q;
    assign map_w    = in_latch ? I_ROTAG_IMG_W : w_q;
    assign map_q    = in_latch ? eff_turns(I_ROTAG_MODE, I_ROTAG_DIR) : q_q;

    rot_coord_map #(.DW(DW)) u_map (
        .r     (r_q),
        .c     (c_q),
        .h     (map_h),
        .w     (map_w),
        .q     (map_q),
        .row   (row),
        .col   (col),
        .new_h (map_new_h),
        .new_w (map_new_w)
    );

    // 16x16 -> 32 products; the address sums wrap at AW bits.
    logic [2*DW-1:0] prod_rd, prod_wr;
    assign prod_rd = (2*DW)'(r_q) * (2*DW)'(w_q);
    assign prod_wr = (2*DW)'(row) * (2*DW)'(map_new_w);

    assign dma.valid   = valid_q;
    assign dma.rd_addr = src_q + AW'(prod_rd) + AW'(c_q);
    assign dma.wr_addr = dst_q + AW'(prod_wr) + AW'(col);

    logic start_edge, last_px, last_col;
    assign start_edge = I_ROTAG_START & ~start_q;
    assign last_col   = (c_q == w_q - DW'(1));
    assign last_px    = last_col && (r_q == h_q - DW'(1));

    always_ff @(posedge I_ROTAG_PCLK) begin
        if (!I_ROTAG_PRESET_N) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            r_q     <= '0;
            c_q     <= '0;
            h_q     <= '0;
            w_q     <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            q_q     <= '0;
            new_h_q <= '0;
            new_w_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= I_ROTAG_START;
            done_q  <= 1'b0;
            if (I_ROTAG_SRESET) begin
                // Abort silently; rotated dimensions stay visible.
                state   <= ST_IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                r_q     <= '0;
                c_q     <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (start_edge) begin
                        state  <= ST_LATCH;
                        busy_q <= 1'b1;
                    end
                    ST_LATCH: begin
                        src_q   <= I_ROTAG_SRC_IMG;
                        dst_q   <= I_ROTAG_DST_IMG;
                        h_q     <= I_ROTAG_IMG_H;
                        w_q     <= I_ROTAG_IMG_W;
                        q_q     <= map_q;
                        new_h_q <= map_new_h;
                        new_w_q <= map_new_w;
                        r_q     <= '0;
                        c_q     <= '0;
                        if (I_ROTAG_IMG_H == '0 || I_ROTAG_IMG_W == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            valid_q <= 1'b1;
                        end
                    end
                    ST_RUN: if (valid_q && dma.ready) begin
                        if (last_px) begin
                            valid_q <= 1'b0;
                            state   <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (last_col) begin
                            c_q <= '0;
                            r_q <= r_q + DW'(1);
                        end else begin
                            c_q <= c_q + DW'(1);
                        end
                    end
                    ST_DONE: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign O_ROTAG_NEW_H = new_h_q;
    assign O_ROTAG_NEW_W = new_w_q;
    assign O_ROTAG_BUSY  = busy_q;
    assign O_ROTAG_DONE  = done_q;

`ifdef ROTAG_PERF_CNT_EN
    // Counts every RUN cycle including stalls; holds after the job ends.
    logic [31:0] cycles_q;
    always_ff @(posedge I_ROTAG_PCLK) begin
        if (!I_ROTAG_PRESET_N)
            cycles_q <= '0;
        else if (!I_ROTAG_SRESET) begin
            if (state == ST_LATCH)
                cycles_q <= '0;
            else if (state == ST_RUN)
                cycles_q <= cycles_q + 32'd1;
        end
    end
    assign O_ROTAG_CYCLES = cycles_q;
`else
    assign O_ROTAG_CYCLES = '0;
`endif

endmodule

// File: tb/tb_rot_addr_gen.sv
// tb_rot_addr_gen: scoreboard bench for rot_addr_gen. Expected address pairs
// come from a coordinate-rotation model (repeated clockwise quarter turns)
// and are queued at job issue; a negedge monitor pops them on handshakes.
module tb_rot_addr_gen;
    import rot_pkg::*;

    localparam int AW = 32;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] src, dst;
    logic [DW-1:0] img_h, img_w;
    logic [1:0]    mode;
    logic          dir, start, sreset;
    logic [DW-1:0] new_h, new_w;
    logic          busy, done;
    logic [31:0]   cycles;

    always #5 clk = ~clk;

    rot_addr_gen_if #(.AW(AW)) dma ();

    rot_addr_gen #(.AW(AW), .DW(DW)) dut (
        .I_ROTAG_PCLK     (clk),
        .I_ROTAG_PRESET_N (rst_n),
        .I_ROTAG_SRC_IMG  (src),
        .I_ROTAG_DST_IMG  (dst),
        .I_ROTAG_IMG_H    (img_h),
        .I_ROTAG_IMG_W    (img_w),
        .I_ROTAG_MODE     (mode),
        .I_ROTAG_DIR      (dir),
        .I_ROTAG_START    (start),
        .I_ROTAG_SRESET   (sreset),
        .dma              (dma),
        .O_ROTAG_NEW_H    (new_h),
        .O_ROTAG_NEW_W    (new_w),
        .O_ROTAG_BUSY     (busy),
        .O_ROTAG_DONE     (done),
        .O_ROTAG_CYCLES   (cycles)
    );

    typedef struct {
        logic [31:0] rd;
        logic [31:0] wr;
    } pair_t;

    pair_t       exp_q[$];
    int          n_chk = 0, n_fail = 0;
    int          hs_cnt = 0, done_cnt = 0;
    int          rdy_mode = 0;   // 0 always, 1 toggle, 2 random, 3 never
    logic        prev_stall = 1'b0;
    logic [31:0] prev_rd, prev_wr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: rotate each source coordinate by q clockwise quarter turns,
    // one turn maps (r,c) in an h x w image to (c, h-1-r) in a w x h image.
    task automatic model(input int h, input int w, input logic [1:0] md, input logic dr,
                         input logic [31:0] s, input logic [31:0] d,
                         output int nh, output int nw);
        int q, rr, cc, hh, ww, t;
        q = dr ? (4 - int'(md)) % 4 : int'(md);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                pair_t p;
                rr = r; cc = c; hh = h; ww = w;
                repeat (q) begin
                    t = rr; rr = cc; cc = hh - 1 - t;
                    t = hh; hh = ww; ww = t;
                end
                p.rd = s + 32'(r * w) + 32'(c);
                p.wr = d + 32'(rr * ww) + 32'(cc);
                exp_q.push_back(p);
            end
        hh = h; ww = w;
        repeat (q) begin t = hh; hh = ww; ww = t; end
        nh = hh; nw = ww;
    endtask

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       dma.ready = 1'b1;
            1:       dma.ready = (dma.ready === 1'b1) ? 1'b0 : 1'b1;
            2:       dma.ready = ($urandom % 4) != 0;
            default: dma.ready = 1'b0;
        endcase
    end

    // Monitor: handshake is sampled half a cycle before the capturing edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dma.valid === 1'b1) begin
                if (prev_stall) begin
                    chk("hold_rd", dma.rd_addr, prev_rd);
                    chk("hold_wr", dma.wr_addr, prev_wr);
                end
                if (dma.ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_pair: got rd 0x%0h wr 0x%0h, required none",
                                 dma.rd_addr, dma.wr_addr);
                    end else begin
                        pair_t e;
                        e = exp_q.pop_front();
                        chk("rd_addr", dma.rd_addr, e.rd);
                        chk("wr_addr", dma.wr_addr, e.wr);
                    end
                    hs_cnt++;
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                chk("pairs_left_at_done", exp_q.size(), 0);
            end
        end
        prev_stall = (rst_n === 1'b1) && (dma.valid === 1'b1) && (dma.ready !== 1'b1);
        prev_rd    = dma.rd_addr;
        prev_wr    = dma.wr_addr;
    end

    // Called at posedge+1; returns at posedge+1 of the first RUN/DONE cycle.
    task automatic start_job(input int h, input int w, input logic [1:0] md, input logic dr,
                             input logic [31:0] s, input logic [31:0] d, input int rmode);
        int nh, nw, lat;
        rdy_mode = rmode;
        img_h = DW'(h); img_w = DW'(w); mode = md; dir = dr; src = s; dst = d;
        model(h, w, md, dr, s, d, nh, nw);
        start = 1'b1;
        lat = 0;
        while (lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) start = 1'b0;
            if (dma.valid === 1'b1 || done === 1'b1) break;
        end
        chk("start_latency", lat, 2);
        chk("new_h", new_h, nh);
        chk("new_w", new_w, nw);
        chk("busy_in_job", busy, 1);
        // Config changes after capture must not disturb the job.
        img_h = DW'($urandom); img_w = DW'($urandom); mode = 2'($urandom);
        dir = 1'($urandom); src = $urandom; dst = $urandom;
    endtask

    task automatic run_job(input int h, input int w, input logic [1:0] md, input logic dr,
                           input logic [31:0] s, input logic [31:0] d, input int rmode,
                           input bit extra_start);
        int hs0, d0, k;
        hs0 = hs_cnt;
        d0  = done_cnt;
        start_job(h, w, md, dr, s, d, rmode);
        if (extra_start) begin
            repeat (2) begin @(posedge clk); #1; end
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        k = 0;
        while (done_cnt == d0 && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done_pulses", done_cnt - d0, 1);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("handshakes", hs_cnt - hs0, h * w);
`ifdef ROTAG_PERF_CNT_EN
        if (rmode == 0) chk("cycles", cycles, h * w);
`else
        chk("cycles", cycles, 0);
`endif
        if (extra_start) begin
            repeat (4) begin @(posedge clk); #1; end
            chk("no_requeued_job", busy, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required test end");
        $fatal(1);
    end

    initial begin
        int k, h, w;
        rst_n = 1'b0; start = 1'b0; sreset = 1'b0;
        src = '0; dst = '0; img_h = '0; img_w = '0; mode = '0; dir = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_valid", dma.valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_new_h", new_h, 0);
        chk("rst_new_w", new_w, 0);
        chk("rst_rd", dma.rd_addr, 0);
        chk("rst_wr", dma.wr_addr, 0);
        chk("rst_cycles", cycles, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_job(2, 3, 2'd1, 1'b0, 32'h1000, 32'h2000, 0, 0);
        run_job(2, 3, 2'd1, 1'b1, 32'h1000, 32'h2000, 0, 0);
        run_job(2, 2, 2'd2, 1'b0, 32'h1000, 32'h2000, 1, 0);
        run_job(0, 5, 2'd0, 1'b0, 32'h1000, 32'h2000, 0, 0);
        run_job(3, 5, 2'd3, 1'b1, 32'h1000, 32'h2000, 0, 1);

        // Soft reset after three handshakes
        start_job(2, 3, 2'd1, 1'b0, 32'h1000, 32'h2000, 0);
        k = 0;
        while (hs_cnt < 3 + 6 * 2 + 4 + 15 && k < 100) begin @(posedge clk); #1; k++; end
        sreset = 1'b1;
        rdy_mode = 3;
        @(posedge clk); #1;
        chk("sreset_valid", dma.valid, 0);
        chk("sreset_busy", busy, 0);
        chk("sreset_keeps_new_h", new_h, 3);
        chk("sreset_keeps_new_w", new_w, 2);
        k = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("sreset_start_ignored", busy, 0);
        chk("sreset_no_done", done_cnt - k, 0);
        chk("sreset_pairs_left", exp_q.size(), 3);
        exp_q.delete();
        sreset = 1'b0;
        @(posedge clk); #1;
        run_job(2, 3, 2'd1, 1'b0, 32'h1000, 32'h2000, 0, 0);

        // Hard reset mid-job
        start_job(4, 4, 2'd2, 1'b1, 32'h3000, 32'h4000, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        rdy_mode = 3;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("hrst_valid", dma.valid, 0);
        chk("hrst_busy", busy, 0);
        chk("hrst_new_h", new_h, 0);
        chk("hrst_new_w", new_w, 0);
        exp_q.delete();
        @(posedge clk); #1;

        // Randomized jobs, including address wrap-around
        for (int i = 0; i < 12; i++) begin
            h = $urandom_range(0, 6);
            w = $urandom_range(1, 7);
            if (i == 5) w = 0;
            run_job(h, w, 2'($urandom), 1'($urandom),
                    (i % 3 == 0) ? 32'hFFFF_FFF8 : $urandom,
                    (i % 4 == 1) ? 32'hFFFF_FFFC : $urandom,
                    $urandom_range(0, 2), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
